// File: rtl/code_to_volts_seq.sv
// Sequential code-to-volts converter: restoring long division by DIVISOR, one BCD digit
// every four cycles (ones digit first, then FRAC_DIGITS fractional digits), with valid/ready on both sides.
module code_to_volts_seq #(
    parameter int IN_WIDTH    = 8,
    parameter int DIVISOR     = 51,
    parameter int FRAC_DIGITS = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_WIDTH-1:0]          in_code,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*(FRAC_DIGITS+1)-1:0] out_bcd,
    output logic                         out_inexact,
    output logic                         busy
);

    localparam int NUM_DIGITS = FRAC_DIGITS + 1;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int MAX_CODE   = (1 << IN_WIDTH) - 1;
    localparam int SAFE_DIV   = (DIVISOR < 1) ? 1 : DIVISOR;
    localparam int MAX_SCALED = 10 * (SAFE_DIV - 1);
    localparam int MAX_CMP    = SAFE_DIV * 8;
    localparam int MAX_A      = (MAX_CODE > MAX_SCALED) ? MAX_CODE : MAX_SCALED;
    localparam int WORK_MAX   = (MAX_A > MAX_CMP) ? MAX_A : MAX_CMP;
    localparam int WORK_W     = $clog2(WORK_MAX + 1);
    localparam int DIG_W      = $clog2(NUM_DIGITS + 1);

    if (DIVISOR < 1) begin : g_bad_divisor
        $error("code_to_volts_seq: DIVISOR must be at least 1");
    end
    if (MAX_CODE / SAFE_DIV > 9) begin : g_bad_range
        $error("code_to_volts_seq: full-scale code would need more than one integer digit");
    end
    if (FRAC_DIGITS < 1) begin : g_bad_frac
        $error("code_to_volts_seq: FRAC_DIGITS must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WORK_W-1:0]  working_q, working_d;
    logic [1:0]         iter_q, iter_d;
    logic [DIG_W-1:0]   digit_q, digit_d;
    logic [3:0]         quot_q, quot_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               inexact_q, inexact_d;

    logic [1:0]         bit_idx;
    logic [WORK_W-1:0]  comparand;
    logic               take;
    logic [WORK_W-1:0]  diff;
    logic [WORK_W-1:0]  scaled;
    logic [3:0]         quot_next;

    // Iteration 0 tests quotient bit 3, iteration 3 tests bit 0.
    assign bit_idx   = 2'd3 - iter_q;
    assign comparand = WORK_W'(DIVISOR) << bit_idx;
    assign take      = (working_q >= comparand);
    assign diff      = take ? (working_q - comparand) : working_q;
    assign quot_next = quot_q | ({3'b000, take} << bit_idx);
    // Remainder is always below DIVISOR here, so times ten fits the working width.
    assign scaled    = (diff << 3) + (diff << 1);

    always_comb begin
        state_d   = state_q;
        working_d = working_q;
        iter_d    = iter_q;
        digit_d   = digit_q;
        quot_d    = quot_q;
        bcd_d     = bcd_q;
        inexact_d = inexact_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    working_d = WORK_W'(in_code);
                    iter_d    = 2'd0;
                    digit_d   = '0;
                    quot_d    = 4'd0;
                    bcd_d     = '0;
                    inexact_d = 1'b0;
                    state_d   = DIV;
                end
            end
            DIV: begin
                busy      = 1'b1;
                working_d = diff;
                quot_d    = quot_next;
                iter_d    = iter_q + 2'd1;
                if (iter_q == 2'd3) begin
                    // Digits enter at the bottom, so the ones digit ends up in the top nibble.
                    bcd_d   = {bcd_q[BCD_W-5:0], quot_next};
                    quot_d  = 4'd0;
                    digit_d = digit_q + DIG_W'(1);
                    if (digit_q == DIG_W'(NUM_DIGITS - 1)) begin
                        inexact_d = (diff != '0);
                        state_d   = DONE;
                    end else begin
                        working_d = scaled;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            working_q <= '0;
            iter_q    <= 2'd0;
            digit_q   <= '0;
            quot_q    <= 4'd0;
            bcd_q     <= '0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            working_q <= working_d;
            iter_q    <= iter_d;
            digit_q   <= digit_d;
            quot_q    <= quot_d;
            bcd_q     <= bcd_d;
            inexact_q <= inexact_d;
        end
    end

    assign out_bcd     = bcd_q;
    assign out_inexact = inexact_q;

endmodule

// File: tb/tb_code_to_volts_seq.sv
// Bench for code_to_volts_seq: default instance with random codes, backpressure and async reset,
// plus a 10-bit / DIVISOR=205 / 4-digit instance swept over every code.
module tb_code_to_volts_seq;

    localparam int A_W    = 8;
    localparam int A_DIV  = 51;
    localparam int A_FRAC = 3;
    localparam int B_W    = 10;
    localparam int B_DIV  = 205;
    localparam int B_FRAC = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic                    a_in_valid = 1'b0;
    logic                    a_in_ready;
    logic [A_W-1:0]          a_in_code = '0;
    logic                    a_out_valid;
    logic                    a_out_ready = 1'b0;
    logic [4*(A_FRAC+1)-1:0] a_out_bcd;
    logic                    a_out_inexact;
    logic                    a_busy;

    logic                    b_in_valid = 1'b0;
    logic                    b_in_ready;
    logic [B_W-1:0]          b_in_code = '0;
    logic                    b_out_valid;
    logic                    b_out_ready = 1'b0;
    logic [4*(B_FRAC+1)-1:0] b_out_bcd;
    logic                    b_out_inexact;
    logic                    b_busy;

    int compared   = 0;
    int mismatched = 0;

    code_to_volts_seq #(.IN_WIDTH(A_W), .DIVISOR(A_DIV), .FRAC_DIGITS(A_FRAC)) dut_a (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_in_code),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bcd(a_out_bcd),
        .out_inexact(a_out_inexact), .busy(a_busy)
    );

    code_to_volts_seq #(.IN_WIDTH(B_W), .DIVISOR(B_DIV), .FRAC_DIGITS(B_FRAC)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bcd(b_out_bcd),
        .out_inexact(b_out_inexact), .busy(b_busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Truncated decimal value of code/divisor: floor(code * 10^frac / divisor), digit by digit.
    function automatic void refModel(input int code, input int divisor, input int frac,
                                     output logic [31:0] bcd, output logic inexact);
        longint scale = 1;
        longint num;
        longint q;
        for (int i = 0; i < frac; i++) scale = scale * 10;
        num     = longint'(code) * scale;
        q       = num / divisor;
        inexact = (num % divisor) != 0;
        bcd     = '0;
        for (int d = 0; d <= frac; d++) begin
            bcd[4*d +: 4] = 4'(q % 10);
            q = q / 10;
        end
    endfunction

    task automatic applyStimulus(input logic [A_W-1:0] code, input int hold, input bit noise);
        logic [31:0] exp_bcd;
        logic        exp_inexact;
        int          edges;
        refModel(int'(code), A_DIV, A_FRAC, exp_bcd, exp_inexact);
        edges = 0;
        while (!a_in_ready && edges < 50) begin
            @(negedge clock);
            edges++;
        end
        checkOutput("a_ready_before_accept", 64'(a_in_ready), 64'd1);
        a_in_code  = code;
        a_in_valid = 1'b1;
        @(posedge clock);
        edges = 0;
        while (edges < 200) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (a_out_valid) break;
            if (noise) begin
                a_in_valid = 1'($urandom_range(1, 0));
                a_in_code  = A_W'($urandom);
            end else begin
                a_in_valid = 1'b0;
            end
        end
        a_in_valid = 1'b0;
        checkOutput("a_out_valid", 64'(a_out_valid), 64'd1);
        checkOutput("a_latency", 64'(edges), 64'(4 * (A_FRAC + 1)));
        checkOutput("a_bcd", 64'(a_out_bcd), 64'(exp_bcd));
        checkOutput("a_inexact", 64'(a_out_inexact), 64'(exp_inexact));
        checkOutput("a_ready_in_done", 64'(a_in_ready), 64'd0);
        checkOutput("a_busy_in_done", 64'(a_busy), 64'd0);
        for (int i = 0; i < hold; i++) begin
            a_in_valid = 1'($urandom_range(1, 0));
            a_in_code  = A_W'($urandom);
            @(negedge clock);
            checkOutput("a_hold_valid", 64'(a_out_valid), 64'd1);
            checkOutput("a_hold_bcd", 64'(a_out_bcd), 64'(exp_bcd));
            checkOutput("a_hold_ready", 64'(a_in_ready), 64'd0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clock);
        a_out_ready = 1'b0;
        checkOutput("a_valid_after_accept", 64'(a_out_valid), 64'd0);
        checkOutput("a_ready_after_accept", 64'(a_in_ready), 64'd1);
        checkOutput("a_bcd_held_idle", 64'(a_out_bcd), 64'(exp_bcd));
    endtask

    task automatic applySweep(input int code);
        logic [31:0] exp_bcd;
        logic        exp_inexact;
        int          edges;
        refModel(code, B_DIV, B_FRAC, exp_bcd, exp_inexact);
        edges = 0;
        while (!b_in_ready && edges < 50) begin
            @(negedge clock);
            edges++;
        end
        b_in_code  = B_W'(code);
        b_in_valid = 1'b1;
        @(posedge clock);
        edges = 0;
        while (edges < 200) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            b_in_valid = 1'b0;
            if (b_out_valid) break;
        end
        checkOutput("b_latency", 64'(edges), 64'(4 * (B_FRAC + 1)));
        checkOutput("b_bcd", 64'(b_out_bcd), 64'(exp_bcd));
        checkOutput("b_inexact", 64'(b_out_inexact), 64'(exp_inexact));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clock);
        @(negedge clock);
        checkOutput("rst_in_ready", 64'(a_in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(a_out_valid), 64'd0);
        checkOutput("rst_busy", 64'(a_busy), 64'd0);
        checkOutput("rst_bcd", 64'(a_out_bcd), 64'd0);
        checkOutput("rst_inexact", 64'(a_out_inexact), 64'd0);
        checkOutput("rst_b_ready", 64'(b_in_ready), 64'd1);
        checkOutput("rst_b_bcd", 64'(b_out_bcd), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        applyStimulus(8'd255, 0, 1'b0);
        checkOutput("kat_255_bcd", 64'(a_out_bcd), 64'h5000);
        checkOutput("kat_255_inexact", 64'(a_out_inexact), 64'd0);
        applyStimulus(8'd128, 0, 1'b0);
        checkOutput("kat_128_bcd", 64'(a_out_bcd), 64'h2509);
        checkOutput("kat_128_inexact", 64'(a_out_inexact), 64'd1);
        applyStimulus(8'd0, 0, 1'b0);
        checkOutput("kat_0_bcd", 64'(a_out_bcd), 64'h0000);
        checkOutput("kat_0_inexact", 64'(a_out_inexact), 64'd0);
        applyStimulus(8'd1, 0, 1'b0);
        checkOutput("kat_1_bcd", 64'(a_out_bcd), 64'h0019);
        checkOutput("kat_1_inexact", 64'(a_out_inexact), 64'd1);

        applyStimulus(8'd200, 20, 1'b0);
        applyStimulus(8'd77, 0, 1'b0);

        // Abort a conversion seven edges in, between clock edges.
        a_in_code  = 8'd255;
        a_in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a_in_valid = 1'b0;
        repeat (6) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_busy", 64'(a_busy), 64'd0);
        checkOutput("arst_in_ready", 64'(a_in_ready), 64'd1);
        checkOutput("arst_out_valid", 64'(a_out_valid), 64'd0);
        checkOutput("arst_bcd", 64'(a_out_bcd), 64'd0);
        checkOutput("arst_inexact", 64'(a_out_inexact), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        applyStimulus(8'd255, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(A_W'($urandom), int'($urandom_range(3, 0)), 1'b1);
        end

        b_out_ready = 1'b1;
        for (int code = 0; code < (1 << B_W); code++) begin
            applySweep(code);
        end
        checkOutput("kat_1023_bcd", 64'(b_out_bcd), 64'h49902);
        checkOutput("kat_1023_inexact", 64'(b_out_inexact), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/code_to_volts_seq.md
Name: code_to_volts_seq

Overview:
- Sequential, parametrised converter from an unsigned ADC/DAC code to a decimal voltage readout: one integer (ones) digit plus FRAC_DIGITS fractional digits, packed BCD.
- Each digit uses the divide-by-DIVISOR, remainder-times-ten scheme, computed by a 4-iteration restoring divider per digit.
- Sits between the converter sample register and the seven-segment/display formatter, with valid/ready handshakes on both sides.
- Supersedes the fixed two-digit combinational converter.

Parameters:
- IN_WIDTH, 8, width of input code.
- DIVISOR, 51, code counts per volt (255/5 for 8-bit, 5 V full scale).
- FRAC_DIGITS, 3, number of digits after the decimal point (>=1).
- Legality: (2^IN_WIDTH-1)/DIVISOR <= 9 and DIVISOR >= 1; elaboration-time error otherwise.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  in_code valid.
- in_ready  out  1  block idle and able to accept.
- in_code  in  IN_WIDTH  unsigned code.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_bcd  out  4*(FRAC_DIGITS+1)  [MSB nibble]=ones digit, then fractional digits in descending weight; LSB nibble = last fractional digit.
- out_inexact  out  1  final remainder nonzero (result truncated).
- busy  out  1  conversion in progress.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, out_bcd=0, out_inexact=0, internal remainder and counters = 0. An in-flight conversion is discarded and no partial result appears.
- States:
  - IDLE: in_ready=1. in_valid=1 latches in_code into the working register, clears digit index and bit counter, and moves to DIV.
  - DIV: busy=1, in_ready=0. Each digit takes exactly 4 cycles; iteration i=3..0 compares working >= DIVISOR<<i.
    - If yes: subtract and set quotient bit i. Otherwise keep the value and clear bit i.
    - After bit 0 the 4-bit quotient is written to its nibble and the digit index increments.
    - If more digits remain, working = remainder*10. Otherwise out_inexact = (remainder != 0) and the state moves to DONE.
  - DONE: out_valid=1; out_bcd and out_inexact stable. out_ready=1 moves to IDLE, and out_valid drops next cycle. in_ready stays 0 in DONE, so a new code is accepted one cycle after the result handoff at the earliest.
- Latency: out_valid asserts exactly 4*(FRAC_DIGITS+1) rising edges after the accepting edge (16 for defaults). Fixed and data-independent.
- Width rules:
  - The working register holds max(2^IN_WIDTH-1, 10*(DIVISOR-1)) and the comparand DIVISOR<<3 without overflow.
  - The ×10 operation is shift-add, with no truncation.
  - Quotient per digit is guaranteed <= 9 by the legality rule for the ones digit and by remainder<DIVISOR for fractional digits.
- Truncation only; no rounding. out_inexact reports a nonzero discarded tail.
- out_bcd is registered, updated only during DIV, and held through DONE and subsequent IDLE until the next acceptance clears it.
- in_valid during DIV or DONE is ignored and not queued. out_ready outside DONE is ignored.

Test Plan:
- Defaults, in_code=255 -> after 16 cycles out_valid=1, out_bcd=0x5000 (5.000), out_inexact=0.
- in_code=128 -> out_bcd=0x2509, out_inexact=1 (128/51=2 r26; 260→5 r5; 50→0 r50; 500→9 r41).
- in_code=0 -> 0x0000, inexact=0. in_code=1 -> 0x0019, inexact=1 (0 r1; 10→0; 100→1 r49; 490→9 r31).
- Backpressure: hold out_ready=0 for 20 cycles after result -> out_valid and out_bcd stable, in_ready=0, in_valid pulses ignored. Release -> IDLE one cycle later; next code accepted with correct result.
- Reset asserted asynchronously at cycle 7 of a conversion -> outputs clear immediately without waiting for an edge. A fresh conversion after deassertion gives the correct value with the full 16-cycle latency.
- Parameter sweep IN_WIDTH=10, DIVISOR=205, FRAC_DIGITS=4: in_code=1023 -> out_bcd=0x49902, inexact=1 (1023/205=4 r203; 2030→9 r185; 1850→9 r5; 50→0 r50; 500→2 r90). Latency 20 cycles. Check the result against a reference model over all 1024 codes.
